status_framer: RTL and testbench

//  Consumes the 24-bit status word stream (data + one-cycle write strobe) produced by the status/debounce stage.

---
 rtl/status_framer_pkg.sv | 29 ++
 rtl/status_framer_fifo.sv | 52 +++++
 rtl/status_framer.sv | 123 ++++++++++++
 tb/tb_status_framer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/status_framer_pkg.sv
// Shared types and helpers for the status word framer.
package status_framer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TAG   = 3'd1,
        ST_B_HI  = 3'd2,
        ST_B_MID = 3'd3,
        ST_B_LO  = 3'd4
    } state_t;

    localparam int FRAME_BYTES = 4;
    localparam int TAG_OVF_BIT = 0;
    localparam int HOLD_W      = (FRAME_BYTES - 1) * 8;

    // Tag byte: source id in the upper seven bits, overflow marker in the low bit.
    function automatic logic [7:0] make_tag(input logic [6:0] src, input logic ovf);
        logic [7:0] t;
        t = {src, 1'b0};
        t[TAG_OVF_BIT] = ovf;
        return t;
    endfunction

    // Saturating 8-bit increment for the drop counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/status_framer_fifo.sv
// Synchronous word FIFO; extra pointer bit distinguishes full from empty.
module status_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update; a push into a full FIFO is only taken when a pop frees a slot.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/status_framer.sv
// Buffers 24-bit status words and serializes each as a 4-byte tagged frame.
module status_framer
    import status_framer_pkg::*;
#(
    parameter int         DEPTH  = 4,
    parameter logic [6:0] SRC_ID = 7'h2A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] in_data,
    input  logic        in_wr,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic [7:0]  drop_cnt
);

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic                ovf_q, ovf_d;
    logic [7:0]          drop_cnt_q, drop_cnt_d;

    logic                fifo_pop, fifo_full, fifo_empty;
    logic [HOLD_W-1:0]   fifo_rdata;
    logic                accept, load, drop;

    status_fifo #(.DEPTH(DEPTH), .WIDTH(HOLD_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_wr),
        .wdata (in_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign drop_cnt = drop_cnt_q;
    assign busy     = !fifo_empty || (state_q != ST_IDLE);

    // Next-state, byte mux, FIFO pop and drop/overflow bookkeeping.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;

        accept   = tx_valid_q && tx_ready;
        // A new word loads from idle, or straight after the last byte is taken.
        load     = !fifo_empty &&
                   ((state_q == ST_IDLE) || ((state_q == ST_B_LO) && accept));
        fifo_pop = load;

        unique case (state_q)
            ST_IDLE: ;
            ST_TAG: if (accept) begin
                state_d   = ST_B_HI;
                tx_data_d = hold_q[23:16];
            end
            ST_B_HI: if (accept) begin
                state_d   = ST_B_MID;
                tx_data_d = hold_q[15:8];
            end
            ST_B_MID: if (accept) begin
                state_d   = ST_B_LO;
                tx_data_d = hold_q[7:0];
            end
            ST_B_LO: if (accept) begin
                state_d    = ST_IDLE;
                tx_valid_d = 1'b0;
            end
            default: begin
                state_d    = ST_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase

        if (load) begin
            state_d    = ST_TAG;
            hold_d     = fifo_rdata;
            tx_data_d  = make_tag(SRC_ID, ovf_q);
            tx_valid_d = 1'b1;
            ovf_d      = 1'b0;
        end

        // A drop sets the overflow marker even in a load cycle.
        drop = in_wr && fifo_full && !fifo_pop;
        if (drop) begin
            ovf_d      = 1'b1;
            drop_cnt_d = sat_inc8(drop_cnt_q);
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Hold register for the word being framed; only written at load.
    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

endmodule

// File: tb/tb_status_framer.sv
// Randomized and directed bench for status_framer with a queue-based reference model.
module tb_status_framer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] in_data = '0;
    logic        in_wr = 1'b0;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        busy;
    logic [7:0]  drop_cnt;

    status_framer #(.DEPTH(DEPTH), .SRC_ID(7'h2A)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_wr    (in_wr),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: word queue, bytes-left-in-frame count, overflow flag, drop count.
    logic [23:0] mq[$];
    logic [7:0]  exp_q[$];
    int          rem = 0;
    bit          m_ovf = 0;
    int          m_drop = 0;
    bit          m_acc, m_ld, m_full;
    logic [23:0] m_w;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            exp_q.delete();
            rem = 0;
            m_ovf = 0;
            m_drop = 0;
        end else begin
            m_acc  = (rem > 0) && tx_ready;
            m_ld   = (mq.size() > 0) && (rem == 0 || (rem == 1 && m_acc));
            m_full = (mq.size() == DEPTH);
            if (m_ld) begin
                m_w = mq.pop_front();
                exp_q.push_back({7'h2A, m_ovf});
                exp_q.push_back(m_w[23:16]);
                exp_q.push_back(m_w[15:8]);
                exp_q.push_back(m_w[7:0]);
                rem = 4;
                m_ovf = 0;
            end else if (m_acc) begin
                rem--;
            end
            if (in_wr) begin
                if (!m_full || m_ld) mq.push_back(in_data);
                else begin
                    if (m_drop < 255) m_drop++;
                    m_ovf = 1;
                end
            end
        end
    end

    // Monitor: compares outputs against the model on every falling edge.
    logic [7:0] prev_data;
    bit         prev_stall = 0;

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("tx_valid", {31'd0, tx_valid}, {31'd0, rem > 0});
            chk("busy", {31'd0, busy}, {31'd0, (mq.size() > 0) || (rem > 0)});
            chk("drop_cnt", {24'd0, drop_cnt}, m_drop);
            if (prev_stall && tx_valid) chk("stall_stable", {24'd0, tx_data}, {24'd0, prev_data});
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL tx_byte: got %0h, expected no byte (t=%0t)", tx_data, $time);
                end else begin
                    chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end else begin
            prev_stall = 0;
        end
    end

    task automatic cyc(input bit wr, input logic [23:0] d, input bit rdy);
        in_wr    = wr;
        in_data  = d;
        tx_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, 24'h0, rdy);
    endtask

    function automatic logic [23:0] rnd24();
        return 24'($urandom);
    endfunction

    logic [7:0] dc;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_valid", {31'd0, tx_valid}, 0);
        chk("rst_tx_data", {24'd0, tx_data}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_drop_cnt", {24'd0, drop_cnt}, 0);
        rst_n = 1'b1;
        idle(2, 1'b1);

        // Single word: tag appears two cycles after the write
        cyc(1'b1, 24'h123456, 1'b1);
        chk("lat_n1_valid", {31'd0, tx_valid}, 0);
        cyc(1'b0, 24'h0, 1'b1);
        chk("lat_n2_valid", {31'd0, tx_valid}, 1);
        chk("lat_n2_tag", {24'd0, tx_data}, 32'h54);
        idle(4, 1'b1);
        chk("single_busy_low", {31'd0, busy}, 0);

        // Stall at the middle byte
        cyc(1'b1, 24'h123456, 1'b0);
        cyc(1'b0, 24'h0, 1'b0);
        cyc(1'b0, 24'h0, 1'b1);
        cyc(1'b0, 24'h0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 24'h0, 1'b0);
            chk("stall_data", {24'd0, tx_data}, 32'h34);
            chk("stall_valid", {31'd0, tx_valid}, 1);
        end
        idle(4, 1'b1);

        // Overflow: one word in flight, then DEPTH+2 more with the link stalled
        cyc(1'b1, rnd24(), 1'b0);
        cyc(1'b0, 24'h0, 1'b0);
        for (int i = 0; i < DEPTH + 2; i++) cyc(1'b1, rnd24(), 1'b0);
        chk("ovf_drop_cnt", {24'd0, drop_cnt}, 2);
        idle(5 * (DEPTH + 2), 1'b1);

        // Back-to-back frames are contiguous
        cyc(1'b1, 24'hA1B2C3, 1'b1);
        cyc(1'b1, 24'hD4E5F6, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk("contig_valid", {31'd0, tx_valid}, 1);
            cyc(1'b0, 24'h0, 1'b1);
        end
        chk("contig_end", {31'd0, tx_valid}, 0);
        idle(2, 1'b1);

        // Full FIFO with a write coinciding with the pop at the last byte
        cyc(1'b1, rnd24(), 1'b0);
        cyc(1'b0, 24'h0, 1'b0);
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, rnd24(), 1'b0);
        dc = drop_cnt;
        idle(3, 1'b1);
        cyc(1'b1, 24'h0BEEF0, 1'b1);
        chk("full_pop_drop", {24'd0, drop_cnt}, {24'd0, dc});
        idle(5 * (DEPTH + 2), 1'b1);

        // Asynchronous reset mid-frame
        cyc(1'b1, rnd24(), 1'b1);
        cyc(1'b0, 24'h0, 1'b1);
        cyc(1'b0, 24'h0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, tx_valid}, 0);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_drop", {24'd0, drop_cnt}, 0);
        idle(2, 1'b1);
        rst_n = 1'b1;
        cyc(1'b1, 24'hABCDEF, 1'b1);
        cyc(1'b0, 24'h0, 1'b1);
        chk("post_rst_tag", {24'd0, tx_data}, 32'h54);
        idle(5, 1'b1);

        // Random traffic
        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 99) < 40, rnd24(), $urandom_range(0, 99) < 70);
        idle(40, 1'b1);

        // Drop counter saturation
        for (int i = 0; i < 270; i++) cyc(1'b1, rnd24(), 1'b0);
        chk("drop_sat", {24'd0, drop_cnt}, 32'hFF);
        idle(40, 1'b1);

        chk("drain_exp_empty", exp_q.size(), 0);
        chk("drain_busy", {31'd0, busy}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
